// File: rtl/halton_nd_fsm_param.sv
// halton_nd_fsm_param
//
// Sequential N-channel Halton point generator. Each channel computes the
// van der Corput radical inverse of index k in its own base (2, 3, 5 or 7)
// and returns it as an unsigned Q0.FRAC_W fraction. A burst of points with
// consecutive indices is streamed out over a valid/ready handshake.
//
// Per channel the work is split into three phases:
//   INIT  : load the index and clear the reversed-digit accumulator.
//   DIGIT : peel one base-b digit off the index per cycle, appending it to
//           rev and growing den = b^n.
//   DIV   : FRAC_W cycles of restoring division, giving floor(rev*2^F/den).
// After the last channel the point is presented in OUT until it is taken.
//
// Parameters:
//   NUM_CH  number of channels (1..8)
//   K_W     index width in bits
//   FRAC_W  result precision in bits (>= 2)
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   start      begin a burst (only honoured while ready=1)
//   k_in       first index of the burst
//   burst_len  number of points in the burst (0 behaves as 1)
//   base_sel   per-channel base code, channel c at [2c+1:2c]:
//              00=2, 01=3, 10=5, 11=7
//   k_stride   index increment between points (HALTON_LEAP_EN builds only)
//   ready      idle, a start will be accepted
//   out_valid  result/out_k hold a complete point
//   out_ready  consumer accepts the presented point
//   out_k      index of the presented point
//   result     packed results, channel c at [c*FRAC_W +: FRAC_W]
//   done       one-cycle pulse on the handshake of the last point
//
// Build option:
//   HALTON_LEAP_EN  when defined, adds the k_stride input; successive
//                   indices are k_in + i*k_stride (mod 2^K_W). When not
//                   defined the stride is fixed at 1.

module halton_nd_fsm_param #(
    parameter int NUM_CH = 4,
    parameter int K_W    = 32,
    parameter int FRAC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [K_W-1:0]           k_in,
    input  logic [K_W-1:0]           burst_len,
    input  logic [2*NUM_CH-1:0]      base_sel,
`ifdef HALTON_LEAP_EN
    input  logic [K_W-1:0]           k_stride,
`endif
    output logic                     ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K_W-1:0]           out_k,
    output logic [NUM_CH*FRAC_W-1:0] result,
    output logic                     done
);

    // rev/den/remainder need headroom: den = b^n can reach 7*2^K_W, and the
    // remainder is shifted left once before being compared with den.
    localparam int W     = K_W + 4;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W = $clog2(FRAC_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DIGIT,
        S_DIV,
        S_OUT
    } state_t;

    state_t state;
    state_t state_next;

    // Burst context, captured when a start is accepted
    logic [K_W-1:0]      k_cur;
    logic [K_W-1:0]      remain;
    logic [2*NUM_CH-1:0] bases;
    logic [K_W-1:0]      stride;

    // Per-channel working registers
    logic [CH_W-1:0]     ch;
    logic [K_W-1:0]      q;
    logic [W-1:0]        rev;
    logic [W-1:0]        den;
    logic [BIT_W-1:0]    bit_cnt;
    logic [FRAC_W-1:0]   quo;

    // Combinational helpers
    logic [1:0]          base_code;
    logic [K_W-1:0]      base_k;
    logic [K_W-1:0]      q_div;
    logic [K_W-1:0]      digit;
    logic [W-1:0]        base_w;
    logic [W-1:0]        rev_next;
    logic [W-1:0]        den_next;
    logic [W-1:0]        rem_shift;
    logic                rem_ge;
    logic [W-1:0]        rem_next;
    logic [FRAC_W-1:0]   quo_next;
    logic                last_ch;
    logic                last_bit;
    logic                last_pt;

`ifndef HALTON_LEAP_EN
    // Without the leap option the index simply counts up by one
    assign stride = K_W'(1);
`endif

    // Digit extraction and division step. The divide by the selected base
    // is a divide by a small constant, so each case arm collapses to a
    // fixed constant-divider rather than a general divider. During DIV the
    // rev register doubles as the running remainder, which is safe because
    // rev < den always holds on entry to DIV.
    always_comb begin
        base_code = bases[2*ch +: 2];
        base_k    = K_W'(2);
        q_div     = q >> 1;
        case (base_code)
            2'b01: begin
                base_k = K_W'(3);
                q_div  = q / K_W'(3);
            end
            2'b10: begin
                base_k = K_W'(5);
                q_div  = q / K_W'(5);
            end
            2'b11: begin
                base_k = K_W'(7);
                q_div  = q / K_W'(7);
            end
            default: begin
                base_k = K_W'(2);
                q_div  = q >> 1;
            end
        endcase
        digit     = q - q_div * base_k;
        base_w    = W'(base_k);
        rev_next  = rev * base_w + W'(digit);
        den_next  = den * base_w;
        rem_shift = rev << 1;
        rem_ge    = (rem_shift >= den);
        rem_next  = rem_ge ? (rem_shift - den) : rem_shift;
        quo_next  = {quo[FRAC_W-2:0], rem_ge};
    end

    // Loop-termination flags shared by the FSM and the datapath
    always_comb begin
        last_ch  = (ch == CH_W'(NUM_CH - 1));
        last_bit = (bit_cnt == BIT_W'(FRAC_W - 1));
        last_pt  = (remain == K_W'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs. The index zero skips DIGIT entirely,
    // which leaves rev=0/den=1 and therefore a zero result. done is masked
    // by rst so that an aborted burst never reports completion.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = S_INIT;
                end
            end
            S_INIT: begin
                state_next = (k_cur == '0) ? S_DIV : S_DIGIT;
            end
            S_DIGIT: begin
                if (q_div == '0) begin
                    state_next = S_DIV;
                end
            end
            S_DIV: begin
                if (last_bit) begin
                    state_next = last_ch ? S_OUT : S_INIT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done       = last_pt && !rst;
                    state_next = last_pt ? S_IDLE : S_INIT;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath. Burst parameters are captured on the accepting cycle so
    // later input changes cannot disturb a burst in flight. A channel's
    // result is written only at the end of its DIV phase and out_k only on
    // entry to OUT, so both stay stable while a point waits for out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_cur   <= '0;
            remain  <= '0;
            bases   <= '0;
`ifdef HALTON_LEAP_EN
            stride  <= '0;
`endif
            ch      <= '0;
            q       <= '0;
            rev     <= '0;
            den     <= '0;
            bit_cnt <= '0;
            quo     <= '0;
            out_k   <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_cur  <= k_in;
                        remain <= (burst_len == '0) ? K_W'(1) : burst_len;
                        bases  <= base_sel;
`ifdef HALTON_LEAP_EN
                        stride <= k_stride;
`endif
                        ch     <= '0;
                    end
                end
                S_INIT: begin
                    q       <= k_cur;
                    rev     <= '0;
                    den     <= W'(1);
                    bit_cnt <= '0;
                end
                S_DIGIT: begin
                    q   <= q_div;
                    rev <= rev_next;
                    den <= den_next;
                end
                S_DIV: begin
                    rev     <= rem_next;
                    quo     <= quo_next;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (last_bit) begin
                        result[ch*FRAC_W +: FRAC_W] <= quo_next;
                        if (last_ch) begin
                            out_k <= k_cur;
                        end else begin
                            ch <= ch + CH_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        remain <= remain - K_W'(1);
                        k_cur  <= k_cur + stride;
                        ch     <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halton_nd_fsm_param.sv
// tb_halton_nd_fsm_param
//
// Self-checking bench for halton_nd_fsm_param. A reference model computes
// each expected point directly from the radical-inverse definition
// (digit-weighted fraction scaled to Q0.FRAC_W) and its expected compute
// latency; accepted bursts are expanded into a queue of expected points
// that a single compare process consumes on every handshake.

module tb_halton_nd_fsm_param;

    localparam int NUM_CH = 4;
    localparam int K_W    = 32;
    localparam int FRAC_W = 16;
    localparam int RW     = NUM_CH * FRAC_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [K_W-1:0]      k_in;
    logic [K_W-1:0]      burst_len;
    logic [2*NUM_CH-1:0] base_sel;
    logic                ready;
    logic                out_valid;
    logic                out_ready;
    logic [K_W-1:0]      out_k;
    logic [RW-1:0]       result;
    logic                done;
`ifdef HALTON_LEAP_EN
    logic [K_W-1:0]      k_stride;
`endif

    typedef struct {
        logic [K_W-1:0] k;
        logic [RW-1:0]  res;
        int             lat;
        bit             last;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           e_cur;
    int             n_compared   = 0;
    int             n_mismatched = 0;
    int             cyc          = 0;
    int             t_ref        = 0;
    bit             vld_prev     = 1'b0;
    bit             hold_prev    = 1'b0;
    logic [K_W-1:0] held_k;
    logic [RW-1:0]  held_res;
    logic [K_W-1:0] last_k       = '0;
    logic [RW-1:0]  last_res     = '0;
    logic [RW-1:0]  prev_res     = '0;
    int             ready_mode   = 0;
    bit             junk_en      = 1'b0;
    logic [K_W-1:0] stride_val   = 1;

    halton_nd_fsm_param #(
        .NUM_CH (NUM_CH),
        .K_W    (K_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_in      (k_in),
        .burst_len (burst_len),
        .base_sel  (base_sel),
`ifdef HALTON_LEAP_EN
        .k_stride  (k_stride),
`endif
        .ready     (ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_k     (out_k),
        .result    (result),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    function automatic int base_of(input logic [1:0] code);
        case (code)
            2'b00:   return 2;
            2'b01:   return 3;
            2'b10:   return 5;
            default: return 7;
        endcase
    endfunction

    function automatic int ndig(input longint k, input int b);
        int n = 0;
        longint q = k;
        while (q > 0) begin
            q = q / b;
            n++;
        end
        return n;
    endfunction

    // Radical inverse: sum of d_i * b^-(i+1), evaluated over the common
    // denominator b^n and truncated to FRAC_W fractional bits.
    function automatic longint vdc(input longint k, input int b);
        int     n   = ndig(k, b);
        longint big = 1;
        longint w;
        longint num = 0;
        longint q   = k;
        for (int i = 0; i < n; i++) big = big * b;
        w = big / b;
        for (int i = 0; i < n; i++) begin
            num = num + (q % b) * w;
            w   = w / b;
            q   = q / b;
        end
        return (num * (longint'(1) << FRAC_W)) / big;
    endfunction

    function automatic exp_t make_point(input logic [K_W-1:0] k,
                                        input logic [2*NUM_CH-1:0] bs,
                                        input bit last);
        exp_t   e;
        longint v;
        int     b;
        e.k    = k;
        e.res  = '0;
        e.lat  = 0;
        e.last = last;
        for (int c = 0; c < NUM_CH; c++) begin
            b = base_of(bs[2*c +: 2]);
            v = vdc(longint'(k), b);
            e.res[c*FRAC_W +: FRAC_W] = v[FRAC_W-1:0];
            e.lat = e.lat + 1 + ndig(longint'(k), b) + FRAC_W;
        end
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Single compare process: records accepted bursts, then checks latency,
    // held values under backpressure, and every handshake against the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            vld_prev  = 1'b0;
            hold_prev = 1'b0;
            if (done) checkOutput("done_in_reset", done, 0);
        end else begin
            if (start && ready) begin
                int             n;
                logic [K_W-1:0] kk;
                logic [K_W-1:0] st;
`ifdef HALTON_LEAP_EN
                st = k_stride;
`else
                st = 1;
`endif
                n  = (burst_len == 0) ? 1 : int'(burst_len);
                kk = k_in;
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back(make_point(kk, base_sel, i == n - 1));
                    kk = kk + st;
                end
                t_ref = cyc;
            end
            if (out_valid && !vld_prev) begin
                if (exp_q.size() == 0) checkOutput("spurious_valid", out_valid, 0);
                else checkOutput("latency", cyc - t_ref - 1, exp_q[0].lat);
            end
            if (hold_prev) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_k", out_k, held_k);
                checkOutput("hold_result", result, held_res);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e_cur = exp_q.pop_front();
                checkOutput("out_k", out_k, e_cur.k);
                checkOutput("result", result, e_cur.res);
                checkOutput("done", done, e_cur.last);
                prev_res = last_res;
                last_res = result;
                last_k   = out_k;
                t_ref    = cyc;
            end else if (done) begin
                checkOutput("spurious_done", done, 0);
            end
            hold_prev = out_valid && !out_ready;
            held_k    = out_k;
            held_res  = result;
            vld_prev  = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic stepCycle();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (junk_en) begin
            start     = !ready && ($urandom_range(0, 3) == 0);
            k_in      = $urandom;
            burst_len = $urandom;
            base_sel  = 8'($urandom);
        end
    endtask

    task automatic applyStimulus(input logic [K_W-1:0] k, input logic [K_W-1:0] len,
                                 input logic [2*NUM_CH-1:0] bs);
        int guard = 0;
        while (!ready && guard < 6000) begin
            stepCycle();
            guard++;
        end
        if (!ready) checkOutput("ready_timeout", ready, 1);
        k_in      = k;
        burst_len = len;
        base_sel  = bs;
`ifdef HALTON_LEAP_EN
        k_stride  = stride_val;
`endif
        start     = 1'b1;
        stepCycle();
        start     = 1'b0;
        k_in      = $urandom;
        burst_len = $urandom;
        base_sel  = 8'($urandom);
`ifdef HALTON_LEAP_EN
        k_stride  = $urandom;
`endif
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (!(ready && exp_q.size() == 0) && guard < 6000) begin
            stepCycle();
            guard++;
        end
        if (!(ready && exp_q.size() == 0)) checkOutput("burst_timeout", 0, 1);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k_in      = '0;
        burst_len = '0;
        base_sel  = '0;
        out_ready = 1'b1;
`ifdef HALTON_LEAP_EN
        k_stride  = 1;
`endif
        stepCycle();
        stepCycle();
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_out_k", out_k, 0);
        rst = 1'b0;

        // Pin the model to hand-computed values
        checkOutput("model_k1_b2", vdc(1, 2), 64'h8000);
        checkOutput("model_k1_b3", vdc(1, 3), 64'h5555);
        checkOutput("model_k1_b5", vdc(1, 5), 64'h3333);
        checkOutput("model_k1_b7", vdc(1, 7), 64'h2492);
        checkOutput("model_k3_b3", vdc(3, 3), 64'h1C71);
        checkOutput("model_kmax_b2", vdc(64'hFFFFFFFF, 2), 64'hFFFF);

        // Single point, bases 2,3,5,7
        ready_mode = 0;
        applyStimulus(1, 1, 8'b11_10_01_00);
        waitIdle();
        checkOutput("k1_ch0", last_res[0 +: 16], 16'h8000);
        checkOutput("k1_ch1", last_res[16 +: 16], 16'h5555);
        checkOutput("k1_ch2", last_res[32 +: 16], 16'h3333);
        checkOutput("k1_ch3", last_res[48 +: 16], 16'h2492);

        // Three-point burst, bases 2,3,2,2
        applyStimulus(3, 3, 8'b00_00_01_00);
        waitIdle();
        checkOutput("k5_out_k", last_k, 5);
        checkOutput("k5_ch0", last_res[0 +: 16], 16'hA000);
        checkOutput("k5_ch1", last_res[16 +: 16], 16'hC71C);
        checkOutput("k4_ch1", prev_res[16 +: 16], 16'h71C7);

        // Backpressure with ignored start pulses
        ready_mode = 1;
        applyStimulus(10, 3, 8'b01_11_10_00);
        begin
            int guard = 0;
            while (!out_valid && guard < 1000) begin
                stepCycle();
                guard++;
            end
            checkOutput("bp_valid_seen", out_valid, 1);
        end
        junk_en = 1'b1;
        for (int i = 0; i < 20; i++) stepCycle();
        ready_mode = 0;
        waitIdle();
        junk_en = 1'b0;
        start   = 1'b0;
        checkOutput("bp_last_k", last_k, 12);

        // Index wrap and zero
        applyStimulus(32'hFFFFFFFF, 2, 8'b00_00_00_00);
        waitIdle();
        checkOutput("wrap_first_ch0", prev_res[0 +: 16], 16'hFFFF);
        checkOutput("wrap_out_k", last_k, 0);
        checkOutput("wrap_zero_res", last_res, 0);

        // Reset while dividing
        applyStimulus(1, 1, 8'b11_10_01_00);
        for (int i = 0; i < 5; i++) stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("abort_ready", ready, 1);
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_done", done, 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) stepCycle();
        checkOutput("abort_idle", ready, 1);
        applyStimulus(1, 1, 8'b11_10_01_00);
        waitIdle();
        checkOutput("after_abort_ch0", last_res[0 +: 16], 16'h8000);

        // Randomised bursts with random backpressure and stray starts
        ready_mode = 2;
        junk_en    = 1'b1;
        for (int b = 0; b < 8; b++) begin
            logic [K_W-1:0] k;
            k = (b % 3 == 0) ? (32'hFFFFFFFF - K_W'($urandom_range(0, 2))) : K_W'($urandom);
`ifdef HALTON_LEAP_EN
            stride_val = K_W'($urandom_range(0, 5));
`endif
            applyStimulus(k, K_W'($urandom_range(0, 4)), 8'($urandom));
            waitIdle();
        end
        junk_en = 1'b0;
        start   = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/halton_nd_fsm_param.md
Name: halton_nd_fsm_param

Overview:
- Parametrised sequential low-discrepancy point generator. Computes an N-channel Halton point: each channel is a van der Corput radical inverse of index k in its own base.
- Successor to the fixed 32-bit single-shot sphere generators. Generalises channel count, index width and output precision, adds base 5, and adds burst streaming with valid/ready backpressure.
- Feeds the sphere/Hopf mapping stages and DMA-style sample consumers.

Parameters:
- NUM_CH, 4, number of channels (1..8).
- K_W, 32, index width in bits.
- FRAC_W, 16, result precision; each result is unsigned Q0.FRAC_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a burst; sampled only when ready=1.
- k_in  in  K_W  first index of the burst.
- burst_len  in  K_W  number of points in the burst; 0 is treated as 1.
- base_sel  in  2*NUM_CH  per-channel base: 00=2, 01=3, 10=5, 11=7. Channel c uses bits [2c+1:2c].
- ready  out  1  idle; can accept start.
- out_valid  out  1  result bus holds a complete point.
- out_ready  in  1  consumer accepts the point.
- out_k  out  K_W  index of the presented point.
- result  out  NUM_CH*FRAC_W  packed results; channel c at [c*FRAC_W +: FRAC_W].
- done  out  1  one-cycle pulse on the handshake of the last point of a burst.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: ready=1, out_valid=0, done=0, out_k=0, result=0, FSM=IDLE.
- Reset mid-operation aborts the burst. No further out_valid and no done are produced.
- When start is accepted, k_in, burst_len and base_sel are latched. Later changes to these inputs do not affect the burst in progress.
- start while ready=0 is ignored.
- States: IDLE -> INIT -> DIGIT -> DIV -> (next channel: INIT | all channels done: OUT) -> OUT -> (more points: INIT, channel 0, k+1 | last point: IDLE).
- INIT, 1 cycle: q=k, rev=0, den=1.
- DIGIT, 1 cycle per base-b digit of k, loop while q!=0: d=q mod b; q=q/b; rev=rev*b+d; den=den*b.
  - k=0 takes 0 DIGIT cycles, giving rev=0, den=1.
  - Divide by constant b is combinational, with a case on the selected base.
- DIV, FRAC_W cycles, restoring division MSB-first: r starts at rev; each cycle r=r<<1; if r>=den then r=r-den and the bit is 1, else the bit is 0.
  - Result = floor(rev*2^FRAC_W/den), which is exact truncation.
  - rev, den and r are K_W+4 bits wide (den <= 7*2^K_W). No overflow can occur.
- Per-channel latency is 1 + n_c + FRAC_W cycles, where n_c is the digit count of k in base b_c.
- out_valid rises in the cycle after the last DIV cycle of the last channel.
- OUT: result and out_k are stable while out_valid=1 and out_ready=0.
  - A handshake is out_valid&&out_ready. On the handshake out_valid drops the next cycle unless the next point is already complete; computation of the next point starts the cycle after the handshake.
  - With out_ready held at 1, consecutive points are separated by their compute latency. There is no extra bubble beyond the OUT cycle.
- Index advances modulo 2^K_W; wrap from 2^K_W-1 to 0 is legal. k=0 yields all-zero results.
- done pulses in the same cycle as the handshake of point burst_len. ready=1 from the following cycle.
- ready=0 from the cycle after start is accepted until that return to IDLE.

Optional Feature:
- Macro HALTON_LEAP_EN.
- Defined: adds input port k_stride (K_W bits, latched on start). Successive indices are k_in + i*k_stride, modulo 2^K_W. A stride of 0 is legal and repeats the same point.
- Undefined: no k_stride port; stride is fixed at 1.

Test Plan:
- Defaults; rst=1 for 2 cycles -> ready=1, out_valid=0, result=0, done=0.
- k_in=1, burst_len=1, bases [2,3,5,7] -> result ch0..3 = 0x8000, 0x5555, 0x3333, 0x2492. out_valid appears 72 cycles after start is sampled. done pulses with the handshake.
- k_in=3, bases [2,3,2,2], burst_len=3 with out_ready=1:
  - k=3 -> ch0 0xC000, ch1 0x1C71.
  - k=4 -> ch0 0x2000, ch1 0x71C7.
  - k=5 -> ch0 0xA000, ch1 0xC71C.
  - out_k sequence is 3, 4, 5; done coincides with k=5.
- Backpressure: out_ready=0 for 20 cycles during out_valid -> result and out_k are held. No point is dropped or duplicated. start pulses during the burst are ignored.
- Wrap and zero: k_in=0xFFFFFFFF, burst_len=2, base 2 -> first point ch0 = 0xFFFF (truncated), second point out_k=0 with all-zero results.
- Assert rst mid-DIV -> next cycle ready=1, out_valid=0, and no done. A new burst with k_in=1 then reproduces the 0x8000 result.
